l2_burst_bridge: RTL
====================

# l2_burst_bridge

Sits directly below the L1 data cache. Services the cache's line-burst requests (`l2_rreq`/`l2_wreq`, `l2_burst_size`, `l2_busy`, one word per cycle) by converting them into single-word request/acknowledge transactions on the memory bus. A 16-word burst buffer decouples the cache's fixed one-word-per-cycle streaming from arbitrary memory latency.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width; fixed, other values unsupported.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `l1_rreq`  in  1  read-burst request, one-cycle pulse
- `l1_wreq`  in  1  write-burst request, one-cycle pulse
- `l1_addr`  in  32  burst base byte address, sampled with request
- `l1_burst_size`  in  5  burst length in words, sampled with request
- `l1_wdata`  in  32  write-burst data stream
- `l1_rdata`  out  32  read-burst data stream
- `l1_busy`  out  1  high: cache must wait; falling edge starts data phase
- `mem_req`  out  1  memory word request
- `mem_we`  out  1  1 = write, 0 = read; valid with `mem_req`
- `mem_addr`  out  32  word-aligned byte address
- `mem_wdata`  out  32  write data
- `mem_rdata`  in  32  read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion of current word
- `err`  out  1  sticky timeout flag (see Configuration)

## Operation
- Effective length `len = l1_burst_size`; values 0 and 17–31 are treated as 16.
- Word `i` address: `{l1_addr[31:2], 2'b00} + 4*i`, modulo 2^32.
- Requests are accepted only in IDLE. A request outside IDLE is ignored. If both requests arrive in the same cycle, the write wins.
- States:
  - IDLE: `l1_busy=0`, `mem_req=0`.
    - `l1_wreq` → WSETUP.
    - `l1_rreq` → RFETCH.
  - WSETUP: one cycle with `l1_busy=0`; `l1_wdata` is ignored. → WFILL.
  - WFILL: capture `l1_wdata` into `buf[i]` on each of `len` consecutive cycles with `l1_busy=0`. After the last word → WDRAIN.
  - WDRAIN: `l1_busy=1`. Issue `len` memory writes from `buf[0..len-1]`. After the last `mem_ack` → IDLE.
  - RFETCH: `l1_busy=1`. Issue `len` memory reads; store `mem_rdata` into `buf[i]` on each `mem_ack`. After the last ack → RSTREAM.
  - RSTREAM: `l1_busy=0`. `l1_rdata = buf[k]` in the k-th RSTREAM cycle (k = 0..len-1). → IDLE after `len` cycles.
- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable until `mem_ack` is sampled high.
  - The next word's request is presented the cycle after the ack, so the bus sustains one word per cycle if `mem_ack` stays high.
  - `mem_ack` while `mem_req=0` is ignored.

## Timing
- Reset values: `l1_busy=0`, `l1_rdata=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `err=0`, state IDLE, counters 0. Buffer contents are not cleared.
- Reset mid-operation: return to IDLE next cycle; any outstanding memory word is abandoned.
- Write: request sampled at edge of cycle 0. Cycle 1 is WSETUP. Words are captured in cycles 2..len+1. `l1_busy` rises in cycle len+2. The first `mem_req` is in cycle len+2.
- Read: request sampled at edge of cycle 0. `l1_busy=1` from cycle 1. With zero-wait memory (ack in the same cycle as req), the last ack is in cycle len, `l1_busy` falls in cycle len+1, and word 0 is on `l1_rdata` in that same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `L2_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit per-word wait counter is cleared on each new `mem_req`.
  - On reaching 255 with no ack: drop `mem_req` for one cycle and treat the word as complete. A read word stores 32'hDEADBEEF.
  - Set `err` (sticky until reset). The burst continues normally.
- Not defined: wait for `mem_ack` indefinitely; `err` is tied 0; no counter logic.

## Structure
- Package `l2_bridge_pkg`:
  - state enum (IDLE, WSETUP, WFILL, WDRAIN, RFETCH, RSTREAM)
  - `MAX_BURST=16`
  - `TIMEOUT_CYC=255`
  - `TIMEOUT_FILL=32'hDEADBEEF`
- Sub-module `burst_buffer`: 16×32 register file with one synchronous write port and one registered read port.

## Test plan
- Write burst, size 8, base 0x0000_1040, data 0x11..0x88 in cycles 2–9, ack every cycle → memory receives 8 writes at 0x1040..0x105C in order; `l1_busy` high cycles 10–17.
- Read burst, size 8, base 0x2000, memory returns addr^0xA5A5A5A5 with 3-cycle ack latency → `l1_busy` falls once; `l1_rdata` shows the 8 words on 8 consecutive cycles starting in the falling cycle.
- Write then read (dirty eviction), size 8, with the read request one cycle after the write completes → both complete; `l1_rdata` is correct; no overlap of `mem_req` between the bursts.
- Sizes 1, 16 and 0 → 1, 16 and 16 memory words respectively; base 0xFFFF_FFF0 with size 8 wraps to address 0x0000_0000.
- Reset asserted mid-RFETCH → next cycle `mem_req=0`, `l1_busy=0`, IDLE; a new read after reset completes correctly.
- `L2_BRIDGE_TIMEOUT_EN` defined, ack withheld on word 3 of a read → word 3 = 0xDEADBEEF, `err=1` and stays set; the other words are correct.

Source files
------------

// File: rtl/l2_bridge_pkg.sv
// l2_bridge_pkg: state encoding, burst limits and timeout constants shared by l2_burst_bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l2_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WFILL,
        WDRAIN,
        RFETCH,
        RSTREAM
    } state_t;

    localparam int MAX_BURST = 16;
    localparam int BUF_AW = $clog2(MAX_BURST);
    localparam int TIMEOUT_CYC = 255;
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

    // Index of the last word of a burst; size 0 and oversize requests mean a full line.
    function automatic logic [BUF_AW-1:0] last_index(input logic [4:0] burst_size);
        if (burst_size == 5'd0 || burst_size > 5'(MAX_BURST)) begin
            return BUF_AW'(MAX_BURST - 1);
        end
        return BUF_AW'(burst_size - 5'd1);
    endfunction

endpackage

// File: rtl/burst_buffer.sv
// burst_buffer: 16-word line buffer between the cache stream and the memory bus.
// Latency: write lands at the clock edge; read data is registered, valid the cycle after rd_en.
// Backpressure: none; the owner sequences every access.
module burst_buffer
    import l2_bridge_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BUF_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [MAX_BURST];

    // Storage write; contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read with write-through, so a word written at this edge can be read at the same edge
    // (needed for one-word bursts where the only word is also the first one to leave).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/l2_burst_bridge.sv
// l2_burst_bridge: turns L1 line bursts into single-word req/ack memory transactions; L2_BRIDGE_TIMEOUT_EN adds a per-word watchdog.
// Latency: write drain starts the cycle after the last fill word; read stream starts the cycle after the last ack.
// Backpressure: l1_busy stalls the cache during memory phases; each memory word is held until mem_ack.
module l2_burst_bridge
    import l2_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l1_rreq,
    input  logic              l1_wreq,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic [4:0]        l1_burst_size,
    input  logic [DATA_W-1:0] l1_wdata,
    output logic [DATA_W-1:0] l1_rdata,
    output logic              l1_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    state_t            state;
    logic [BUF_AW-1:0] idx;
    logic [BUF_AW-1:0] idx_inc;
    logic [BUF_AW-1:0] last_idx;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] req_base;
    logic              at_last;
    logic              timeout_hit;
    logic              word_done;
    logic              unused_addr_lsb;

    logic              buf_wr_en;
    logic [BUF_AW-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic              buf_rd_en;
    logic [BUF_AW-1:0] buf_rd_addr;
    logic [DATA_W-1:0] buf_rd_data;

    assign req_base        = {l1_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_lsb = ^l1_addr[1:0];
    assign idx_inc         = idx + BUF_AW'(1);
    assign at_last         = (idx == last_idx);
    assign word_done       = mem_req && (mem_ack || timeout_hit);

    // The buffer read register drives both data outputs: it holds the word being drained to memory,
    // and during RSTREAM it holds the word being streamed to the cache.
    assign l1_rdata  = buf_rd_data;
    assign mem_wdata = buf_rd_data;

    burst_buffer #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr_en),
        .wr_addr (buf_wr_addr),
        .wr_data (buf_wr_data),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

`ifdef L2_BRIDGE_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_r;

    assign timeout_hit = mem_req && !mem_ack && (wait_cnt == 8'(TIMEOUT_CYC));
    assign err         = err_r;

    // Count stall cycles of the outstanding word; restarts for every new word.
    always_ff @(posedge clk) begin
        if (reset || !mem_req || word_done) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Sticky error: remembers that at least one word was abandoned by the watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (timeout_hit) begin
            err_r <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Buffer port steering: fill from the cache, drain to memory, fetch from memory, stream to the cache.
    // Reads are issued one edge early so the registered read data lines up with the bus/stream cycle.
    always_comb begin
        buf_wr_en   = 1'b0;
        buf_wr_addr = idx;
        buf_wr_data = l1_wdata;
        buf_rd_en   = 1'b0;
        buf_rd_addr = '0;
        case (state)
            WFILL: begin
                buf_wr_en = 1'b1;
                buf_rd_en = at_last;
            end
            WDRAIN: begin
                buf_rd_en   = word_done && !at_last;
                buf_rd_addr = idx_inc;
            end
            RFETCH: begin
                buf_wr_en   = word_done;
                buf_wr_data = mem_ack ? mem_rdata : TIMEOUT_FILL;
                buf_rd_en   = word_done && at_last;
            end
            RSTREAM: begin
                buf_rd_en   = !at_last;
                buf_rd_addr = idx_inc;
            end
            default: ;
        endcase
    end

    // Control FSM: accepts bursts only in IDLE and owns the registered cache/bus handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            last_idx  <= '0;
            base_addr <= '0;
            l1_busy   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (l1_wreq) begin
                        state     <= WSETUP;
                        last_idx  <= last_index(l1_burst_size);
                        base_addr <= req_base;
                    end else if (l1_rreq) begin
                        state    <= RFETCH;
                        last_idx <= last_index(l1_burst_size);
                        l1_busy  <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= req_base;
                    end
                end
                WSETUP: begin
                    state <= WFILL;
                end
                WFILL: begin
                    if (at_last) begin
                        state    <= WDRAIN;
                        idx      <= '0;
                        l1_busy  <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= base_addr;
                    end else begin
                        idx <= idx_inc;
                    end
                end
                WDRAIN, RFETCH: begin
                    if (word_done) begin
                        if (at_last) begin
                            mem_req <= 1'b0;
                            l1_busy <= 1'b0;
                            idx     <= '0;
                            state   <= (state == WDRAIN) ? IDLE : RSTREAM;
                        end else begin
                            // A timed-out word leaves one idle bus cycle before the next request.
                            idx      <= idx_inc;
                            mem_addr <= mem_addr + ADDR_W'(4);
                            mem_req  <= !timeout_hit;
                        end
                    end else if (!mem_req) begin
                        mem_req <= 1'b1;
                    end
                end
                RSTREAM: begin
                    if (at_last) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
